// File: rtl/xbar_pkg.sv
// Shared crossbar types and constants used by the master-side mux and the
// slave-side arbiter.
package xbar_pkg;

   localparam int XBAR_N = 32;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   typedef logic       master_idx_t;
   typedef logic [1:0] grant_t;

   localparam logic   CMD_READ   = 1'b0;
   localparam logic   CMD_WRITE  = 1'b1;
   localparam grant_t GRANT_NONE = 2'b00;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: combinational one-hot pick, pointer moves to
// the other master whenever the caller strobes update for the current pick.
module rr_arbiter_2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] grant_next
);
   import xbar_pkg::*;

   logic prefer_second;

   always_comb begin
      grant_next = GRANT_NONE;
      case (req)
         2'b01:   grant_next = 2'b01;
         2'b10:   grant_next = 2'b10;
         2'b11:   grant_next = prefer_second ? 2'b10 : 2'b01;
         default: grant_next = GRANT_NONE;
      endcase
   end

   // after serving master 1 prefer master 2, and vice versa
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prefer_second <= 1'b0;
      end else if (update) begin
         prefer_second <= grant_next[0];
      end else begin
         prefer_second <= prefer_second;
      end
   end

endmodule

// File: rtl/slave_port_arbiter.sv
// Slave-side half of the 2x2 crossbar: round-robin merge of two masters onto
// one slave port, grant held until ack, abandon, or watchdog expiry.
module slave_port_arbiter #(
   parameter int N       = xbar_pkg::XBAR_N,
   parameter int TIMEOUT = 16,
   parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         master_1_req,
   input  logic [N-1:0] master_1_addr,
   input  logic         master_1_cmd,
   input  logic [N-1:0] master_1_wdata,
   output logic         master_1_ack,
   output logic [N-1:0] master_1_rdata,
   output logic         master_1_err,
   input  logic         master_2_req,
   input  logic [N-1:0] master_2_addr,
   input  logic         master_2_cmd,
   input  logic [N-1:0] master_2_wdata,
   output logic         master_2_ack,
   output logic [N-1:0] master_2_rdata,
   output logic         master_2_err,
   output logic         slave_req,
   output logic [N-1:0] slave_addr,
   output logic         slave_cmd,
   output logic [N-1:0] slave_wdata,
   input  logic         slave_ack,
   input  logic [N-1:0] slave_rdata,
   output logic [1:0]   grant
);
   import xbar_pkg::*;

   // keeps the counter at least one bit wide when the watchdog is disabled
   localparam int CW = (TO_W > 0) ? TO_W : 1;

   state_t        state;
   logic [CW-1:0] wd_count;
   logic [1:0]    arb_req;
   logic [1:0]    grant_next;
   logic          arb_update;
   logic          own_1;
   logic          own_2;
   logic          done_ack;
   logic          timeout_hit;

   assign own_1 = (state == BUSY) && grant[0];
   assign own_2 = (state == BUSY) && grant[1];

   always_comb begin
      slave_req   = 1'b0;
      slave_addr  = {N{1'b0}};
      slave_cmd   = CMD_READ;
      slave_wdata = {N{1'b0}};
      if (own_1 && master_1_req) begin
         slave_req   = 1'b1;
         slave_addr  = master_1_addr;
         slave_cmd   = master_1_cmd;
         slave_wdata = master_1_wdata;
      end else if (own_2 && master_2_req) begin
         slave_req   = 1'b1;
         slave_addr  = master_2_addr;
         slave_cmd   = master_2_cmd;
         slave_wdata = master_2_wdata;
      end else begin
         slave_req   = 1'b0;
         slave_addr  = {N{1'b0}};
         slave_cmd   = CMD_READ;
         slave_wdata = {N{1'b0}};
      end
   end

   assign done_ack = slave_req && slave_ack;

   generate
      if (TIMEOUT > 0) begin : g_watchdog
         assign timeout_hit = slave_req && !slave_ack && (wd_count == CW'(TIMEOUT - 1));
      end else begin : g_no_watchdog
         assign timeout_hit = 1'b0;
      end
   endgenerate

   // while busy, feeding the owner back as the only request makes grant_next
   // name the master being completed when the pointer is updated
   assign arb_req    = (state == BUSY) ? grant : {master_2_req, master_1_req};
   assign arb_update = done_ack || timeout_hit;

   rr_arbiter_2 u_rr (
      .clk        (clk),
      .rst        (rst),
      .req        (arb_req),
      .update     (arb_update),
      .grant_next (grant_next)
   );

   assign master_1_ack   = own_1 && done_ack;
   assign master_2_ack   = own_2 && done_ack;
   assign master_1_rdata = master_1_ack ? slave_rdata : {N{1'b0}};
   assign master_2_rdata = master_2_ack ? slave_rdata : {N{1'b0}};
   assign master_1_err   = own_1 && timeout_hit;
   assign master_2_err   = own_2 && timeout_hit;

   // busy ends on ack, watchdog expiry, or the owner dropping its request
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         grant    <= GRANT_NONE;
         wd_count <= {CW{1'b0}};
      end else begin
         case (state)
            IDLE: begin
               if (grant_next != GRANT_NONE) begin
                  state    <= BUSY;
                  grant    <= grant_next;
                  wd_count <= {CW{1'b0}};
               end else begin
                  state    <= IDLE;
                  grant    <= GRANT_NONE;
                  wd_count <= {CW{1'b0}};
               end
            end
            BUSY: begin
               if (!slave_req || done_ack || timeout_hit) begin
                  state    <= IDLE;
                  grant    <= GRANT_NONE;
                  wd_count <= {CW{1'b0}};
               end else begin
                  state    <= BUSY;
                  grant    <= grant;
                  wd_count <= wd_count + CW'(1);
               end
            end
            default: begin
               state    <= IDLE;
               grant    <= GRANT_NONE;
               wd_count <= {CW{1'b0}};
            end
         endcase
      end
   end

endmodule
